// File: rtl/board_ctrl_m_if.sv
// Move-protocol bus between the move generators (master) and board_ctrl_m (slave).
// Optional feature macro: BOARD_UNDO_EN adds the undo strobe.
interface board_ctrl_m_if;
  logic [3:0]  update_loc;
  logic        submit;
  logic        game_reset;
`ifdef BOARD_UNDO_EN
  logic        undo;
`endif
  logic        turn;
  logic [17:0] board;
  logic [3:0]  move_count;
  logic        move_err;
  logic        game_over;
  logic [1:0]  winner;

`ifdef BOARD_UNDO_EN
  modport master (output update_loc, submit, game_reset, undo,
                  input  turn, board, move_count, move_err, game_over, winner);
  modport slave  (input  update_loc, submit, game_reset, undo,
                  output turn, board, move_count, move_err, game_over, winner);
`else
  modport master (output update_loc, submit, game_reset,
                  input  turn, board, move_count, move_err, game_over, winner);
  modport slave  (input  update_loc, submit, game_reset,
                  output turn, board, move_count, move_err, game_over, winner);
`endif
endinterface

// File: rtl/board_ctrl_m.sv
// Tic-tac-toe board controller: validates moves on the shared bus, stores the
// 3x3 board, detects win/tie and owns the turn flag.
// Optional feature macro: BOARD_UNDO_EN (take-back of the most recent move).
module board_ctrl_m #(
  parameter logic FIRST_TURN = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  board_ctrl_m_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state;
  logic [8:0][1:0] cells;
  logic [3:0]      mc;
  logic            turn_r, err_r, over_r, sub_q;
  logic [1:0]      win_r;

  logic            sub_ev, und_ev, loc_ok, cell_free, line_win;
  logic [3:0]      loc_sel;
  logic [1:0]      mark;
  logic [8:0]      hit;

  assign sub_ev    = bus.submit & ~sub_q;
  assign loc_ok    = (bus.update_loc <= 4'd8);
  // out-of-range indices never reach the cell array
  assign loc_sel   = loc_ok ? bus.update_loc : 4'd0;
  assign cell_free = (cells[loc_sel] == 2'b00);
  // mover's mark: player 01, AI 10
  assign mark      = {turn_r, ~turn_r};

`ifdef BOARD_UNDO_EN
  logic            und_q;
  logic [8:0][3:0] hist;
  logic [3:0]      top_idx, top_loc;
  assign und_ev  = bus.undo & ~und_q;
  assign top_idx = (mc != 4'd0) ? (mc - 4'd1) : 4'd0;
  assign top_loc = hist[top_idx];
`else
  assign und_ev  = 1'b0;
`endif

  // per-cell match against the mark just written, then the 8 lines
  always_comb begin
    hit = '0;
    for (int i = 0; i < 9; i++) hit[i] = (cells[i] == mark);
    line_win = (hit[0] & hit[1] & hit[2]) | (hit[3] & hit[4] & hit[5]) |
               (hit[6] & hit[7] & hit[8]) | (hit[0] & hit[3] & hit[6]) |
               (hit[1] & hit[4] & hit[7]) | (hit[2] & hit[5] & hit[8]) |
               (hit[0] & hit[4] & hit[8]) | (hit[2] & hit[4] & hit[6]);
  end

  // game FSM, board storage and edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cells  <= '0;
      mc     <= '0;
      turn_r <= FIRST_TURN;
      err_r  <= 1'b0;
      over_r <= 1'b0;
      win_r  <= 2'b00;
      sub_q  <= 1'b0;
`ifdef BOARD_UNDO_EN
      und_q  <= 1'b0;
      hist   <= '0;
`endif
    end else begin
      sub_q <= bus.submit;
`ifdef BOARD_UNDO_EN
      und_q <= bus.undo;
`endif
      err_r <= 1'b0;
      if (bus.game_reset) begin
        // clear everything except the edge registers, which keep sampling
        state  <= S_IDLE;
        cells  <= '0;
        mc     <= '0;
        turn_r <= FIRST_TURN;
        over_r <= 1'b0;
        win_r  <= 2'b00;
      end else begin
        case (state)
          S_CHECK: begin
            // strobes arriving mid-evaluation are refused; evaluation still completes
            if (sub_ev || und_ev) err_r <= 1'b1;
            if (line_win) begin
              over_r <= 1'b1;
              win_r  <= mark;
              state  <= S_DONE;
            end else if (mc == 4'd9) begin
              over_r <= 1'b1;
              win_r  <= 2'b00;
              state  <= S_DONE;
            end else begin
              turn_r <= ~turn_r;
              state  <= S_IDLE;
            end
          end
          S_IDLE, S_DONE: begin
`ifdef BOARD_UNDO_EN
            // undo wins over a same-cycle submit, which is silently dropped
            if (und_ev) begin
              if (mc != 4'd0) begin
                cells[top_loc] <= 2'b00;
                mc             <= mc - 4'd1;
                turn_r         <= cells[top_loc][1];
                over_r         <= 1'b0;
                win_r          <= 2'b00;
                state          <= S_IDLE;
              end else begin
                err_r <= 1'b1;
              end
            end else
`endif
            if (sub_ev) begin
              if (state == S_IDLE && loc_ok && cell_free) begin
                cells[loc_sel] <= mark;
                mc             <= mc + 4'd1;
                state          <= S_CHECK;
`ifdef BOARD_UNDO_EN
                hist[mc]       <= loc_sel;
`endif
              end else begin
                err_r <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.turn       = turn_r;
  assign bus.board      = cells;
  assign bus.move_count = mc;
  assign bus.move_err   = err_r;
  assign bus.game_over  = over_r;
  assign bus.winner     = win_r;

endmodule
